// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad, entry and timer path.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD_REQ
  } state_t;

  localparam int BCD_W        = 4;
  localparam int NUM_DIGITS   = 4;
  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  // Digit slot positions within the packed MM:SS word, slot 0 at the LSBs.
  localparam int SEC_UNITS_IDX = 0;
  localparam int SEC_TENS_IDX  = 1;
  localparam int MIN_UNITS_IDX = 2;
  localparam int MIN_TENS_IDX  = 3;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when a level input goes high.
// The timer reuses it for its start and clear keys.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/time_entry_decoder.sv
// Assembles an MM:SS cook time from BCD key events and hands it to the timer
// over a req/ack load handshake. Optional feature macro: SEC_CLAMP_EN.
module time_entry_decoder #(
  parameter int NUM_DIGITS = microwave_pkg::NUM_DIGITS,
  parameter int BCD_W      = microwave_pkg::BCD_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BCD_W-1:0]                     bcd_in,
  input  logic                                 pgt,
  input  logic                                 clear,
  input  logic                                 start,
  input  logic                                 load_ack,
  output logic [NUM_DIGITS*BCD_W-1:0]          digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_cnt,
  output logic                                 load_req,
  output logic                                 key_err,
  output logic                                 entry_active
);

  import microwave_pkg::*;

  localparam int DW    = NUM_DIGITS * BCD_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  state_t           state;
  logic [DW-1:0]    dig_q;
  logic [DW-1:0]    present;
  logic [CNT_W-1:0] cnt_q;
  logic             key_ev;
  logic             valid;

  edge_detect u_pgt_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (pgt),
    .rise (key_ev)
  );

  assign valid = (bcd_in <= BCD_W'(BCD_MAX));

`ifdef SEC_CLAMP_EN
  // Out-of-range seconds collapse to x:59; minutes pass through untouched.
  always_comb begin
    present = dig_q;
    if (dig_q[SEC_TENS_IDX*BCD_W +: BCD_W] > BCD_W'(SEC_TENS_MAX)) begin
      present[SEC_TENS_IDX*BCD_W  +: BCD_W] = BCD_W'(SEC_TENS_MAX);
      present[SEC_UNITS_IDX*BCD_W +: BCD_W] = BCD_W'(BCD_MAX);
    end
  end
`else
  assign present = dig_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dig_q        <= '0;
      cnt_q        <= '0;
      load_req     <= 1'b0;
      key_err      <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      key_err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_ev) begin
            if (valid) begin
              dig_q        <= {{(DW-BCD_W){1'b0}}, bcd_in};
              cnt_q        <= CNT_W'(1);
              state        <= ENTRY;
              entry_active <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        ENTRY: begin
          if (clear) begin
            dig_q        <= '0;
            cnt_q        <= '0;
            state        <= IDLE;
            entry_active <= 1'b0;
          end else if (start) begin
            dig_q        <= present;
            state        <= LOAD_REQ;
            load_req     <= 1'b1;
            entry_active <= 1'b0;
          end else if (key_ev) begin
            if (valid && cnt_q < CNT_W'(NUM_DIGITS)) begin
              dig_q <= {dig_q[DW-BCD_W-1:0], bcd_in};
              cnt_q <= cnt_q + 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        LOAD_REQ: begin
          // Keys are swallowed silently while the timer owns the handshake.
          if (clear || load_ack) begin
            dig_q    <= '0;
            cnt_q    <= '0;
            load_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          load_req     <= 1'b0;
          entry_active <= 1'b0;
        end
      endcase
    end
  end

  assign digits    = dig_q;
  assign digit_cnt = cnt_q;

endmodule
